// File: rtl/exe_branch_status_unit.sv
// ---------------------------------------------------------------------------
// exe_branch_status_unit
//
// Execute-stage control block sitting after the ID/EX pipeline register.
// It resolves taken branches into a target address and a flush request,
// stretches that flush over FLUSH_CYCLES cycles with a small FSM, and owns
// the architectural status register read back by the ID stage.
//
// Parameters:
//   FLUSH_CYCLES   cycles flush stays high per taken branch (1..15)
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   freeze         memory-stage stall; all state holds
//   b, s           branch / set-flags flags from ID/EX
//   pc             PC from ID/EX
//   imm_signed_24  branch offset in words
//   alu_flags      {N,Z,C,V} from the ALU
//   stats_clr      synchronous clear of the taken-branch counter
//   branch_taken   selects branch_addr in IF
//   branch_addr    branch target, pc + (sext(imm) << 2)
//   flush          clears IF/ID and ID/EX
//   sr             status register {N,Z,C,V}
//   branch_count   taken-branch count (0 unless stats enabled)
//
// Optional feature:
//   BRANCH_STATS_EN  when defined, builds the saturating 16-bit taken-branch
//                    counter; otherwise branch_count is tied to zero.
// ---------------------------------------------------------------------------
module exe_branch_status_unit #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        b,
  input  logic        s,
  input  logic [31:0] pc,
  input  logic [23:0] imm_signed_24,
  input  logic [3:0]  alu_flags,
  input  logic        stats_clr,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic        flush,
  output logic [3:0]  sr,
  output logic [15:0] branch_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  sr_q, sr_d;
  logic        take;

  // Word offset sign-extended and scaled to bytes; wraps modulo 2^32.
  assign branch_addr = pc + {{6{imm_signed_24[23]}}, imm_signed_24, 2'b00};

  // A branch is only taken from IDLE; while flushing, b belongs to a
  // squashed instruction and is ignored.
  assign take = (state_q == IDLE) && b && !freeze;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    branch_taken = take;
    // In FLUSH the flush holds even under freeze so squashed stages stay clear.
    flush        = take || (state_q == FLUSH);

    if (!freeze) begin
      case (state_q)
        IDLE: begin
          if (s) begin
            sr_d = alu_flags;
          end
          if (take && (FLUSH_CYCLES > 1)) begin
            state_d = FLUSH;
            cnt_d   = 4'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sr_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  assign sr = sr_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] branch_count_q, branch_count_d;

  // Clear wins over an increment; the count saturates instead of wrapping.
  always_comb begin
    branch_count_d = branch_count_q;
    if (!freeze) begin
      if (stats_clr) begin
        branch_count_d = 16'd0;
      end else if (take && (branch_count_q != 16'hFFFF)) begin
        branch_count_d = branch_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count_q <= 16'd0;
    end else begin
      branch_count_q <= branch_count_d;
    end
  end

  assign branch_count = branch_count_q;
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr;
  assign branch_count     = 16'd0;
`endif

endmodule

// File: tb/tb_exe_branch_status_unit.sv
// ---------------------------------------------------------------------------
// tb_exe_branch_status_unit
//
// Self-checking bench. The main instance uses FLUSH_CYCLES=3; a second
// instance with FLUSH_CYCLES=1 drives the long taken-branch counter run.
// Expected values per cycle come from a small reference model and are queued
// when stimulus is driven, then popped and compared when outputs are sampled.
// ---------------------------------------------------------------------------
module tb_exe_branch_status_unit;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int FC = 3;

  logic        clk;
  logic        rst;
  logic        freeze, b, s, statsClr;
  logic [31:0] pc;
  logic [23:0] imm;
  logic [3:0]  aluFlags;
  logic        branchTaken, flush;
  logic [31:0] branchAddr;
  logic [3:0]  sr;
  logic [15:0] branchCount;

  logic        sB, sClr;
  logic        sTaken, sFlush;
  logic [31:0] sAddr;
  logic [3:0]  sSr;
  logic [15:0] sCount;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic        taken;
    logic        flush;
    logic [31:0] addr;
    logic [3:0]  sr;
    logic [15:0] count;
  } exp_t;

  exp_t sbQ[$];

  // Reference model: remaining flush cycles after the current one.
  int          mLeft;
  logic [3:0]  mSr;
  logic [15:0] mCount;

  exe_branch_status_unit #(.FLUSH_CYCLES(FC)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .b            (b),
    .s            (s),
    .pc           (pc),
    .imm_signed_24(imm),
    .alu_flags    (aluFlags),
    .stats_clr    (statsClr),
    .branch_taken (branchTaken),
    .branch_addr  (branchAddr),
    .flush        (flush),
    .sr           (sr),
    .branch_count (branchCount)
  );

  exe_branch_status_unit #(.FLUSH_CYCLES(1)) dutStats (
    .clk          (clk),
    .rst          (rst),
    .freeze       (1'b0),
    .b            (sB),
    .s            (1'b0),
    .pc           (32'h0000_0000),
    .imm_signed_24(24'h000000),
    .alu_flags    (4'h0),
    .stats_clr    (sClr),
    .branch_taken (sTaken),
    .branch_addr  (sAddr),
    .flush        (sFlush),
    .sr           (sSr),
    .branch_count (sCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] targetOf(input logic [31:0] p, input logic [23:0] i);
    logic signed [31:0] off;
    off = 32'(signed'(i)) * 4;
    return p + off;
  endfunction

  task automatic modelReset();
    mLeft  = 0;
    mSr    = 4'h0;
    mCount = 16'h0;
    sbQ.delete();
  endtask

  // Pops the oldest expectation and compares it with the sampled outputs.
  task automatic checkCycle();
    exp_t e;
    if (sbQ.size() == 0) begin
      checkOutput("sbEmpty", 32'd1, 32'd0);
    end else begin
      e = sbQ.pop_front();
      checkOutput("taken", 32'(branchTaken), 32'(e.taken));
      checkOutput("flush", 32'(flush), 32'(e.flush));
      checkOutput("addr",  branchAddr, e.addr);
      checkOutput("sr",    32'(sr), 32'(e.sr));
      checkOutput("count", 32'(branchCount), 32'(e.count));
    end
  endtask

  // Drives one cycle on the main instance, queues its expectation, samples
  // before the next rising edge, then advances the model across that edge.
  task automatic applyStimulus(input logic iB, input logic iS, input logic iFreeze,
                               input logic [31:0] iPc, input logic [23:0] iImm,
                               input logic [3:0] iFlags, input logic iClr);
    exp_t e;
    logic idle;
    @(negedge clk);
    b = iB; s = iS; freeze = iFreeze; pc = iPc; imm = iImm;
    aluFlags = iFlags; statsClr = iClr;

    idle    = (mLeft == 0);
    e.taken = idle && iB && !iFreeze;
    e.flush = e.taken || !idle;
    e.addr  = targetOf(iPc, iImm);
    e.sr    = mSr;
    e.count = mCount;
    sbQ.push_back(e);

    #2;
    checkCycle();

    if (!iFreeze) begin
      if (idle && iS) mSr = iFlags;
      if (STATS) begin
        if (iClr) mCount = 16'h0;
        else if (e.taken && mCount != 16'hFFFF) mCount = mCount + 16'd1;
      end
      if (!idle) mLeft = mLeft - 1;
      else if (e.taken) mLeft = FC - 1;
    end
  endtask

  initial begin
    int flushHigh;
    rst = 1'b1;
    b = 0; s = 0; freeze = 0; pc = 0; imm = 0; aluFlags = 0; statsClr = 0;
    sB = 0; sClr = 0;
    modelReset();

    // Reset with random data on the buses.
    repeat (3) begin
      @(negedge clk);
      s = 1'($urandom); freeze = 1'($urandom); pc = $urandom;
      imm = 24'($urandom); aluFlags = 4'($urandom); statsClr = 1'($urandom);
      b = 1'b0;
      #2;
      checkOutput("rstSr", 32'(sr), 32'd0);
      checkOutput("rstCount", 32'(branchCount), 32'd0);
      checkOutput("rstFlush", 32'(flush), 32'd0);
      checkOutput("rstTaken", 32'(branchTaken), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Bubble: no action, zero target.
    applyStimulus(0, 0, 0, 32'h0, 24'h0, 4'h0, 0);
    checkOutput("bubbleAddr", branchAddr, 32'h0);

    // Forward branch, then its flush tail.
    flushHigh = 0;
    applyStimulus(1, 0, 0, 32'h0000_0100, 24'h000004, 4'h0, 0);
    checkOutput("fwdTaken", 32'(branchTaken), 32'd1);
    checkOutput("fwdFlush", 32'(flush), 32'd1);
    checkOutput("fwdAddr", branchAddr, 32'h0000_0110);
    flushHigh += int'(flush);
    repeat (3) begin
      applyStimulus(0, 0, 0, 32'h0, 24'h0, 4'h0, 0);
      flushHigh += int'(flush);
    end
    checkOutput("flushLen3", 32'(flushHigh), 32'd3);

    // Backward branch and address wrap.
    applyStimulus(0, 0, 0, 32'h0000_0100, 24'hFFFFFF, 4'h0, 0);
    checkOutput("bwdAddr", branchAddr, 32'h0000_00FC);
    applyStimulus(0, 0, 0, 32'h0000_0000, 24'hFFFFFF, 4'h0, 0);
    checkOutput("wrapAddr", branchAddr, 32'hFFFF_FFFC);

    // Branch flags during flush cycles are ignored.
    applyStimulus(1, 0, 0, 32'h0000_2000, 24'h000010, 4'h0, 0);
    applyStimulus(1, 0, 0, 32'h0000_2004, 24'h000010, 4'h0, 0);
    checkOutput("ignoreB2", 32'(branchTaken), 32'd0);
    applyStimulus(1, 0, 0, 32'h0000_2008, 24'h000010, 4'h0, 0);
    checkOutput("ignoreB3", 32'(branchTaken), 32'd0);
    applyStimulus(0, 0, 0, 32'h0, 24'h0, 4'h0, 0);

    // Freeze in the second flush cycle stretches flush to four cycles.
    flushHigh = 0;
    applyStimulus(1, 0, 0, 32'h0000_0040, 24'h000002, 4'h0, 0);
    flushHigh += int'(flush);
    applyStimulus(0, 0, 1, 32'h0, 24'h0, 4'h0, 0);
    flushHigh += int'(flush);
    repeat (3) begin
      applyStimulus(0, 0, 0, 32'h0, 24'h0, 4'h0, 0);
      flushHigh += int'(flush);
    end
    checkOutput("flushLenFrz", 32'(flushHigh), 32'd4);

    // Status register load, frozen load, and combined branch + set-flags.
    applyStimulus(0, 1, 0, 32'h0, 24'h0, 4'b0110, 0);
    applyStimulus(0, 0, 0, 32'h0, 24'h0, 4'b0000, 0);
    checkOutput("srLoad", 32'(sr), 32'b0110);
    applyStimulus(0, 1, 1, 32'h0, 24'h0, 4'b1001, 0);
    applyStimulus(0, 0, 0, 32'h0, 24'h0, 4'b0000, 0);
    checkOutput("srFrozen", 32'(sr), 32'b0110);
    applyStimulus(1, 1, 0, 32'h0000_0300, 24'h000001, 4'b1010, 0);
    checkOutput("bsTaken", 32'(branchTaken), 32'd1);
    applyStimulus(0, 0, 0, 32'h0, 24'h0, 4'b0000, 0);
    checkOutput("bsSr", 32'(sr), 32'b1010);
    repeat (2) applyStimulus(0, 0, 0, 32'h0, 24'h0, 4'h0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                    $urandom, 24'($urandom), 4'($urandom),
                    ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset in the middle of a flush.
    while (mLeft != 0) applyStimulus(0, 0, 0, 32'h0, 24'h0, 4'h0, 0);
    applyStimulus(1, 0, 0, 32'h0000_0500, 24'h000003, 4'h0, 0);
    @(negedge clk);
    b = 1'b0;
    #1;
    checkOutput("midFlushPre", 32'(flush), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midFlushRst", 32'(flush), 32'd0);
    checkOutput("midTakenRst", 32'(branchTaken), 32'd0);
    checkOutput("midSrRst", 32'(sr), 32'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 32'h0, 24'h0, 4'h0, 0);

    // Long taken-branch run on the single-cycle-flush instance.
    @(negedge clk);
    sB = 1'b1;
    repeat (65535) @(negedge clk);
    checkOutput("count65535", 32'(sCount), STATS ? 32'hFFFF : 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("countSat", 32'(sCount), STATS ? 32'hFFFF : 32'd0);
    checkOutput("statsFlush", 32'(sFlush), 32'd1);
    sClr = 1'b1;
    @(negedge clk);
    checkOutput("clrPriority", 32'(sCount), 32'd0);
    sClr = 1'b0;
    @(negedge clk);
    checkOutput("countAfterClr", 32'(sCount), STATS ? 32'd1 : 32'd0);
    sB = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/exe_branch_status_unit.md
# exe_branch_status_unit

Execute-stage control block on the consuming side of the ID/EX pipeline register. It takes the registered decode fields (`b`, `s`, `pc`, `imm_signed_24`) and the ALU flags. It resolves taken branches into a target address plus a flush request, which goes back to IF/ID and ID/EX. It owns the architectural status register that the ID stage reads on `sr_in`. A small FSM stretches the flush over a configurable number of cycles, and a freeze input stalls the block during memory waits.

## Interface
- `FLUSH_CYCLES`, default 1: cycles that `flush` stays high per taken branch; legal range 1..15.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `freeze` input 1: pipeline stall from the memory stage; the block holds all state.
- `b` input 1: branch flag from ID/EX.
- `s` input 1: set-flags flag from ID/EX.
- `pc` input 32: PC value from ID/EX.
- `imm_signed_24` input 24: branch offset from ID/EX, in words.
- `alu_flags` input 4: {N,Z,C,V} from the ALU for the current EXE instruction.
- `stats_clr` input 1: synchronous clear of the statistics counter.
- `branch_taken` output 1: selects `branch_addr` in IF.
- `branch_addr` output 32: branch target.
- `flush` output 1: clears IF/ID and ID/EX.
- `sr` output 4: status register {N,Z,C,V}.
- `branch_count` output 16: number of taken branches (see Configuration).

## Operation
- FSM states: IDLE and FLUSH. A 4-bit counter `cnt` tracks remaining flush cycles.
- In IDLE with `b`=1 and `freeze`=0, the branch is taken:
  - `branch_taken`=1 and `flush`=1, combinationally in that cycle.
  - If FLUSH_CYCLES>1: at the next edge, go to FLUSH with `cnt`=FLUSH_CYCLES-1. Otherwise stay in IDLE.
- In FLUSH:
  - `flush`=1, `branch_taken`=0, `b` is ignored.
  - `cnt` decrements each unfrozen edge.
  - When `cnt`==1, move to IDLE at the edge.
- `branch_addr` = `pc` + (sign-extend(`imm_signed_24`) << 2), computed modulo 2^32. It is driven continuously. It is meaningful only when `branch_taken`=1.
- `sr` loads `alu_flags` at an edge when `s`=1, `freeze`=0 and state is IDLE. Otherwise `sr` holds.
  - `b` and `s` set together: both the branch and the SR update happen.
- `freeze`=1:
  - `branch_taken`=0 and `flush`=0, except in FLUSH, where `flush` stays 1.
  - FSM, `cnt`, `sr` and `branch_count` all hold.
- A bubble (all ID/EX fields zero) causes no action.

## Timing
- Reset values: state IDLE, `cnt`=0, `sr`=4'b0000, `branch_count`=0.
  - Combinational outputs with zero inputs: `branch_taken`=0, `flush`=0, `branch_addr`=0.
- Branch resolution latency is 0 cycles, combinational from the ID/EX outputs. `flush` lasts exactly FLUSH_CYCLES unfrozen cycles.
- `sr` update is visible one edge after the setting instruction.
- `rst` asserted mid-flush goes to IDLE immediately, asynchronously. `flush` drops in the same cycle.
- `stats_clr` takes priority over an increment in the same cycle.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `branch_count` increments by 1 at each edge where a branch is taken.
  - It saturates at 16'hFFFF.
  - `stats_clr`=1 zeroes it at the next edge.
- `BRANCH_STATS_EN` undefined: no counter logic; `branch_count` is tied to 0 and `stats_clr` is ignored. The port list is identical in both builds.

## Test plan
- Reset: assert `rst` with random inputs → `sr`=0, `branch_count`=0, state IDLE. With `b`=0: `flush`=0 and `branch_taken`=0.
- Forward branch: `pc`=0x00000100, `imm_signed_24`=0x000004, `b`=1 → same cycle `branch_taken`=1, `flush`=1, `branch_addr`=0x00000110.
- Backward branch and wrap: `pc`=0x00000100 with `imm_signed_24`=0xFFFFFF → `branch_addr`=0x000000FC. `pc`=0x00000000 with `imm_signed_24`=0xFFFFFF → `branch_addr`=0xFFFFFFFC.
- FLUSH_CYCLES=3:
  - `b`=1 for one cycle → `flush` high for 3 consecutive cycles.
  - `b`=1 in cycles 2–3 → `branch_taken` stays 0.
  - `freeze`=1 in cycle 2 → `flush` extends to 4 cycles.
- SR:
  - `s`=1, `alu_flags`=4'b0110 → `sr`=4'b0110 after the edge.
  - Repeat with `freeze`=1 → `sr` unchanged.
  - `s`=1 with `b`=1 → both the branch and the SR update occur.
- Stats, with `BRANCH_STATS_EN` defined:
  - 65,537 taken branches → `branch_count`=16'hFFFF.
  - `stats_clr` together with a taken branch → 0.
  - With the macro undefined, the same sequence → `branch_count`=0.
